tt_sweep_checker: RTL and testbench
===================================

Name: tt_sweep_checker

Overview:
- Sequential stimulus/capture stage placed directly upstream and downstream of a 7-input combinational classification DUT.
- Drives all 128 input minterms onto x0..x6, captures the DUT's single output into a 128-bit truth table, and compares it against an expected table.
- Reports match, mismatch count and first failing minterm.
- Used to check every generated 7-input network in silicon or emulation without a software testbench.

Parameters:
- DUT_LAT, 0, clock cycles from x driven to f_in valid (0 = purely combinational DUT); legal range 0..4.
- EXPECTED, 128'h0, expected truth table; bit i = f(x = i), with x0 as LSB of i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  terminate sweep and return to IDLE.
- x  out  7  stimulus vector; x[0] drives DUT x0 … x[6] drives DUT x6.
- x_valid  out  1  x carries a live minterm this cycle.
- f_in  in  1  DUT output.
- busy  out  1  high in SWEEP and DRAIN.
- done  out  1  one-cycle pulse when results are final.
- tt  out  128  captured truth table.
- match  out  1  tt == EXPECTED; valid from done, held until next start.
- mismatch_count  out  8  number of differing bits, 0..128.
- first_fail  out  7  lowest failing minterm index; 0 if none.

Behaviour:
- Reset (async, immediate): state IDLE; x=0, x_valid=0, busy=0, done=0, tt=0, match=0, mismatch_count=0, first_fail=0; capture pipeline cleared.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE:
  - start=1 and abort=0 at edge E0 → SWEEP.
  - On that edge: tt, mismatch_count, first_fail and match are cleared.
  - start and abort both high in IDLE: abort wins, no sweep.
- SWEEP:
  - Counter idx steps 0..127, one per cycle, starting the cycle after E0; x=idx, x_valid=1.
  - After idx=127 is driven: go to DRAIN if DUT_LAT>0, otherwise DONE.
  - start is ignored while busy.
- Capture pipeline:
  - A DUT_LAT-deep shift line carries (valid, idx).
  - At the edge ending the cycle in which delayed valid=1: tt[idx_d] <= f_in.
  - If f_in != EXPECTED[idx_d]: mismatch_count increments (saturation is unnecessary; the maximum is 128).
  - first_fail is set to idx_d on the first mismatch only.
- DRAIN: x_valid=0, x holds 127; lasts exactly DUT_LAT cycles, then DONE.
- DONE:
  - One cycle: done=1, busy=0, then IDLE.
  - match = (mismatch_count==0) is registered so that it is valid in the done cycle.
  - done is high in cycle 129+DUT_LAT after E0, counting the cycle after E0 as cycle 1.
- Results (tt, match, mismatch_count, first_fail) hold in IDLE until the next accepted start.
- abort=1 in SWEEP or DRAIN:
  - Next state IDLE and the pipeline is flushed.
  - No done pulse; match=0.
  - Partial tt and mismatch_count remain visible.
- abort in DONE is ignored; done still pulses.
- Reset mid-sweep behaves exactly as power-on reset.
- Width rules:
  - idx is 7 bits and must not wrap to 0 inside a sweep; termination is decoded on idx==127.
  - mismatch_count is 8 bits so that 128 is representable.

Test Plan:
- EXPECTED=128'hfeeafce8fce8e8c0fce8e8c0e8c0a880, DUT_LAT=0, majority-network DUT on x/f_in, pulse start → done in cycle 129; tt equals EXPECTED; match=1; mismatch_count=0; first_fail=0.
- Same EXPECTED, f_in driven as the inverted DUT output → match=0; mismatch_count=128; first_fail=0; tt=~EXPECTED.
- DUT_LAT=2 with the DUT output passed through two registers → done in cycle 131; match=1; x_valid low during the 2 DRAIN cycles.
- EXPECTED with only bit 77 flipped → mismatch_count=1; first_fail=77; match=0.
- abort asserted at idx=40 → no done pulse; busy falls the next cycle; tt[39:0] captured, upper bits 0; a subsequent start completes normally.
- start re-pulsed at idx=10 → ignored, sweep length unchanged. Reset asserted at idx=90 → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: stimulus/capture wrapper around a 7-input combinational
// network. Walks all 128 minterms, records the network output as a truth
// table and compares it bit-by-bit against a reference table.
module tt_sweep_checker #(
    parameter int           DUT_LAT  = 0,
    parameter logic [127:0] EXPECTED = 128'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic [6:0]   x,
    output logic         x_valid,
    input  logic         f_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic         match,
    output logic [7:0]   mismatch_count,
    output logic [6:0]   first_fail
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Last value of the drain counter; only meaningful when DUT_LAT > 0.
    localparam logic [2:0] LAT_LAST = 3'((DUT_LAT > 0) ? (DUT_LAT - 1) : 0);

    state_t       r_state;
    logic [6:0]   r_x;
    logic         r_x_valid;
    logic         r_busy;
    logic         r_done;
    logic         r_match;
    logic [127:0] r_tt;
    logic [7:0]   r_cnt;
    logic [6:0]   r_ff;
    logic [2:0]   r_drain;

    logic         w_abort_act;
    logic         w_cap_valid;
    logic [6:0]   w_cap_idx;
    logic         w_cap_en;
    logic         w_cap_miss;
    logic [7:0]   w_cnt_next;

    // Abort only has an effect while a sweep is in flight.
    assign w_abort_act = abort && ((r_state == S_SWEEP) || (r_state == S_DRAIN));

    generate
        if (DUT_LAT == 0) begin : g_nolat
            // Combinational network: the output belongs to the minterm on x now.
            assign w_cap_valid = r_x_valid;
            assign w_cap_idx   = r_x;
        end else begin : g_lat
            logic       r_pipe_v   [DUT_LAT];
            logic [6:0] r_pipe_idx [DUT_LAT];

            // Delay line aligning (valid, idx) with the network's output latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DUT_LAT; k++) begin
                        r_pipe_v[k]   <= 1'b0;
                        r_pipe_idx[k] <= 7'd0;
                    end
                end else if (w_abort_act) begin
                    for (int k = 0; k < DUT_LAT; k++) begin
                        r_pipe_v[k]   <= 1'b0;
                        r_pipe_idx[k] <= 7'd0;
                    end
                end else begin
                    r_pipe_v[0]   <= r_x_valid;
                    r_pipe_idx[0] <= r_x;
                    for (int k = 1; k < DUT_LAT; k++) begin
                        r_pipe_v[k]   <= r_pipe_v[k-1];
                        r_pipe_idx[k] <= r_pipe_idx[k-1];
                    end
                end
            end

            assign w_cap_valid = r_pipe_v[DUT_LAT-1];
            assign w_cap_idx   = r_pipe_idx[DUT_LAT-1];
        end
    endgenerate

    // The aborting edge captures nothing, so a partial table stops cleanly.
    assign w_cap_en   = w_cap_valid && !w_abort_act;
    assign w_cap_miss = w_cap_en && (f_in != EXPECTED[w_cap_idx]);
    assign w_cnt_next = r_cnt + {7'd0, w_cap_miss};

    // Sweep sequencer plus result capture; match is computed from the count
    // including the final capture so it is already valid in the done cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x       <= 7'd0;
            r_x_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_match   <= 1'b0;
            r_tt      <= '0;
            r_cnt     <= 8'd0;
            r_ff      <= 7'd0;
            r_drain   <= 3'd0;
        end else begin
            r_done <= 1'b0;

            if (w_cap_en) begin
                r_tt[w_cap_idx] <= f_in;
            end
            if (w_cap_miss) begin
                r_cnt <= w_cnt_next;
                if (r_cnt == 8'd0) begin
                    r_ff <= w_cap_idx;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state   <= S_SWEEP;
                        r_tt      <= '0;
                        r_cnt     <= 8'd0;
                        r_ff      <= 7'd0;
                        r_match   <= 1'b0;
                        r_x       <= 7'd0;
                        r_x_valid <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_abort_act) begin
                        r_state   <= S_IDLE;
                        r_x_valid <= 1'b0;
                        r_busy    <= 1'b0;
                        r_match   <= 1'b0;
                    end else if (r_x == 7'd127) begin
                        // Terminate on the last minterm; idx never wraps.
                        r_x_valid <= 1'b0;
                        r_drain   <= 3'd0;
                        if (DUT_LAT == 0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_match <= (w_cnt_next == 8'd0);
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else begin
                        r_x <= r_x + 7'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_abort_act) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_match <= 1'b0;
                    end else if (r_drain == LAT_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_match <= (w_cnt_next == 8'd0);
                    end else begin
                        r_drain <= r_drain + 3'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x              = r_x;
    assign x_valid        = r_x_valid;
    assign busy           = r_busy;
    assign done           = r_done;
    assign tt             = r_tt;
    assign match          = r_match;
    assign mismatch_count = r_cnt;
    assign first_fail     = r_ff;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: three instances (latency 0, latency 2,
// and a reference table with bit 77 flipped) driven from one sequencer.
module tb_tt_sweep_checker;

    localparam logic [127:0] EXP   = 128'hfeeafce8fce8e8c0fce8e8c0e8c0a880;
    localparam logic [127:0] EXP_F = EXP ^ (128'd1 << 77);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, tb_start, tb_abort, inv;
    int   sel;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [127:0] ref_tt;
    assign ref_tt = EXP;

    // Instance 0: latency 0, correct reference, optional inverted output.
    logic [6:0] x0, ff0; logic xv0, f0, b0, d0, m0; logic [127:0] t0; logic [7:0] c0;
    assign f0 = ref_tt[x0] ^ inv;
    tt_sweep_checker #(.DUT_LAT(0), .EXPECTED(EXP)) u_lat0 (
        .clk(clk), .rst(rst), .start(tb_start && sel == 0), .abort(tb_abort && sel == 0),
        .x(x0), .x_valid(xv0), .f_in(f0), .busy(b0), .done(d0), .tt(t0),
        .match(m0), .mismatch_count(c0), .first_fail(ff0));

    // Instance 1: network output passed through two registers.
    logic [6:0] x2, ff2; logic xv2, b2, d2, m2; logic [127:0] t2; logic [7:0] c2;
    logic p1, p2;
    always @(posedge clk) begin
        p1 <= ref_tt[x2];
        p2 <= p1;
    end
    tt_sweep_checker #(.DUT_LAT(2), .EXPECTED(EXP)) u_lat2 (
        .clk(clk), .rst(rst), .start(tb_start && sel == 1), .abort(tb_abort && sel == 1),
        .x(x2), .x_valid(xv2), .f_in(p2), .busy(b2), .done(d2), .tt(t2),
        .match(m2), .mismatch_count(c2), .first_fail(ff2));

    // Instance 2: reference table differs from the network in bit 77.
    logic [6:0] xf, fff; logic xvf, ffi, bf, df, mf; logic [127:0] tf; logic [7:0] cf;
    assign ffi = ref_tt[xf];
    tt_sweep_checker #(.DUT_LAT(0), .EXPECTED(EXP_F)) u_flip (
        .clk(clk), .rst(rst), .start(tb_start && sel == 2), .abort(tb_abort && sel == 2),
        .x(xf), .x_valid(xvf), .f_in(ffi), .busy(bf), .done(df), .tt(tf),
        .match(mf), .mismatch_count(cf), .first_fail(fff));

    // Selected-instance view.
    logic [6:0] m_x, m_ff; logic m_xv, m_busy, m_done, m_match; logic [127:0] m_tt; logic [7:0] m_cnt;
    always_comb begin
        m_x = x0; m_ff = ff0; m_xv = xv0; m_busy = b0; m_done = d0;
        m_match = m0; m_tt = t0; m_cnt = c0;
        if (sel == 1) begin
            m_x = x2; m_ff = ff2; m_xv = xv2; m_busy = b2; m_done = d2;
            m_match = m2; m_tt = t2; m_cnt = c2;
        end else if (sel == 2) begin
            m_x = xf; m_ff = fff; m_xv = xvf; m_busy = bf; m_done = df;
            m_match = mf; m_tt = tf; m_cnt = cf;
        end
    end

    logic       log_xv   [0:255];
    logic       log_busy [0:255];
    logic       log_done [0:255];
    logic [6:0] log_x    [0:255];
    int         done_cyc;
    int         done_cnt;

    // Start a sweep and log outputs for max_cyc cycles (cycle 1 = cycle after E0).
    task automatic drive_sweep(input int abort_at, input int restart_at, input int max_cyc);
        done_cyc = -1;
        done_cnt = 0;
        @(negedge clk); tb_start = 1'b1;
        @(posedge clk); #1; tb_start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            tb_abort = 1'b0;
            tb_start = 1'b0;
            log_xv[c] = m_xv; log_busy[c] = m_busy; log_done[c] = m_done; log_x[c] = m_x;
            if (m_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c - 1 == abort_at) tb_abort = 1'b1;
            if (c - 1 == restart_at) tb_start = 1'b1;
            @(posedge clk); #1;
        end
        tb_abort = 1'b0;
        tb_start = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        n_tests++; if (m_x !== 7'd0) begin n_fail++; $display("FAIL reset_x got %0h want 0", m_x); end
        n_tests++; if (m_xv !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin n_fail++; $display("FAIL reset_ctl got xv=%0b busy=%0b done=%0b want 000", m_xv, m_busy, m_done); end
        n_tests++; if (m_tt !== 128'd0) begin n_fail++; $display("FAIL reset_tt got %0h want 0", m_tt); end
        n_tests++; if (m_match !== 1'b0 || m_cnt !== 8'd0 || m_ff !== 7'd0) begin n_fail++; $display("FAIL reset_res got match=%0b cnt=%0d ff=%0d want 0 0 0", m_match, m_cnt, m_ff); end
        $display("[TB] reset: x=%0d busy=%0b tt=%0h", m_x, m_busy, m_tt);
    endtask

    task automatic test_match_lat0();
        sel = 0; inv = 1'b0;
        drive_sweep(-1, -1, 140);
        n_tests++; if (done_cyc !== 129) begin n_fail++; $display("FAIL lat0_done_cycle got %0d want 129", done_cyc); end
        n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL lat0_done_pulses got %0d want 1", done_cnt); end
        n_tests++; if (log_x[1] !== 7'd0 || log_x[128] !== 7'd127 || log_xv[128] !== 1'b1) begin n_fail++; $display("FAIL lat0_x_seq got x1=%0d x128=%0d xv128=%0b want 0 127 1", log_x[1], log_x[128], log_xv[128]); end
        n_tests++; if (log_busy[128] !== 1'b1 || log_busy[129] !== 1'b0) begin n_fail++; $display("FAIL lat0_busy got %0b%0b want 10", log_busy[128], log_busy[129]); end
        n_tests++; if (m_tt !== ref_tt) begin n_fail++; $display("FAIL lat0_tt got %0h want %0h", m_tt, ref_tt); end
        n_tests++; if (m_match !== 1'b1 || m_cnt !== 8'd0 || m_ff !== 7'd0) begin n_fail++; $display("FAIL lat0_res got match=%0b cnt=%0d ff=%0d want 1 0 0", m_match, m_cnt, m_ff); end
        $display("[TB] lat0 sweep: done_cycle=%0d match=%0b cnt=%0d", done_cyc, m_match, m_cnt);
    endtask

    task automatic test_inverted();
        sel = 0; inv = 1'b1;
        drive_sweep(-1, -1, 140);
        inv = 1'b0;
        n_tests++; if (done_cyc !== 129) begin n_fail++; $display("FAIL inv_done_cycle got %0d want 129", done_cyc); end
        n_tests++; if (m_tt !== ~ref_tt) begin n_fail++; $display("FAIL inv_tt got %0h want %0h", m_tt, ~ref_tt); end
        n_tests++; if (m_match !== 1'b0 || m_cnt !== 8'd128 || m_ff !== 7'd0) begin n_fail++; $display("FAIL inv_res got match=%0b cnt=%0d ff=%0d want 0 128 0", m_match, m_cnt, m_ff); end
        $display("[TB] inverted sweep: done_cycle=%0d match=%0b cnt=%0d", done_cyc, m_match, m_cnt);
    endtask

    task automatic test_lat2();
        sel = 1;
        drive_sweep(-1, -1, 140);
        n_tests++; if (done_cyc !== 131) begin n_fail++; $display("FAIL lat2_done_cycle got %0d want 131", done_cyc); end
        n_tests++; if (log_xv[128] !== 1'b1 || log_xv[129] !== 1'b0 || log_xv[130] !== 1'b0) begin n_fail++; $display("FAIL lat2_xv got %0b%0b%0b want 100", log_xv[128], log_xv[129], log_xv[130]); end
        n_tests++; if (log_busy[130] !== 1'b1 || log_busy[131] !== 1'b0 || log_x[130] !== 7'd127) begin n_fail++; $display("FAIL lat2_drain got busy130=%0b busy131=%0b x130=%0d want 1 0 127", log_busy[130], log_busy[131], log_x[130]); end
        n_tests++; if (m_tt !== ref_tt || m_match !== 1'b1 || m_cnt !== 8'd0) begin n_fail++; $display("FAIL lat2_res got tt=%0h match=%0b cnt=%0d want %0h 1 0", m_tt, m_match, m_cnt, ref_tt); end
        $display("[TB] lat2 sweep: done_cycle=%0d match=%0b cnt=%0d", done_cyc, m_match, m_cnt);
    endtask

    task automatic test_bit77();
        sel = 2;
        drive_sweep(-1, -1, 140);
        n_tests++; if (done_cyc !== 129) begin n_fail++; $display("FAIL flip_done_cycle got %0d want 129", done_cyc); end
        n_tests++; if (m_match !== 1'b0 || m_cnt !== 8'd1 || m_ff !== 7'd77) begin n_fail++; $display("FAIL flip_res got match=%0b cnt=%0d ff=%0d want 0 1 77", m_match, m_cnt, m_ff); end
        n_tests++; if (m_tt !== ref_tt) begin n_fail++; $display("FAIL flip_tt got %0h want %0h", m_tt, ref_tt); end
        $display("[TB] bit77 sweep: match=%0b cnt=%0d first_fail=%0d", m_match, m_cnt, m_ff);
    endtask

    task automatic test_abort();
        logic [39:0] want_lo;
        want_lo = ref_tt[39:0];
        sel = 0;
        drive_sweep(40, -1, 160);
        n_tests++; if (log_x[41] !== 7'd40 || log_busy[41] !== 1'b1 || log_busy[42] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got x41=%0d busy41=%0b busy42=%0b want 40 1 0", log_x[41], log_busy[41], log_busy[42]); end
        n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", done_cnt); end
        n_tests++; if (m_tt[39:0] !== want_lo || m_tt[127:40] !== 88'd0) begin n_fail++; $display("FAIL abort_tt got %0h want low40=%0h upper 0", m_tt, want_lo); end
        n_tests++; if (m_match !== 1'b0 || m_xv !== 1'b0) begin n_fail++; $display("FAIL abort_match got match=%0b xv=%0b want 0 0", m_match, m_xv); end
        $display("[TB] abort at idx 40: done_pulses=%0d tt=%0h", done_cnt, m_tt);
        drive_sweep(-1, -1, 140);
        n_tests++; if (done_cyc !== 129 || m_match !== 1'b1 || m_tt !== ref_tt) begin n_fail++; $display("FAIL abort_resweep got done=%0d match=%0b want 129 1", done_cyc, m_match); end
        $display("[TB] sweep after abort: done_cycle=%0d match=%0b", done_cyc, m_match);
    endtask

    task automatic test_restart();
        sel = 0;
        drive_sweep(-1, 10, 140);
        n_tests++; if (done_cyc !== 129 || done_cnt !== 1) begin n_fail++; $display("FAIL restart_len got done=%0d pulses=%0d want 129 1", done_cyc, done_cnt); end
        n_tests++; if (log_x[12] !== 7'd11 || m_match !== 1'b1) begin n_fail++; $display("FAIL restart_seq got x12=%0d match=%0b want 11 1", log_x[12], m_match); end
        $display("[TB] start re-pulsed at idx 10: done_cycle=%0d", done_cyc);
    endtask

    task automatic test_reset_mid();
        sel = 0; inv = 1'b1;
        @(negedge clk); tb_start = 1'b1;
        @(posedge clk); #1; tb_start = 1'b0;
        repeat (90) @(posedge clk);
        #1;
        n_tests++; if (m_x !== 7'd90 || m_cnt !== 8'd90) begin n_fail++; $display("FAIL rstmid_pre got x=%0d cnt=%0d want 90 90", m_x, m_cnt); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (m_x !== 7'd0 || m_xv !== 1'b0 || m_busy !== 1'b0 || m_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctl got x=%0d xv=%0b busy=%0b done=%0b want 0 0 0 0", m_x, m_xv, m_busy, m_done); end
        n_tests++; if (m_tt !== 128'd0 || m_cnt !== 8'd0 || m_ff !== 7'd0 || m_match !== 1'b0) begin n_fail++; $display("FAIL rstmid_res got tt=%0h cnt=%0d ff=%0d match=%0b want 0", m_tt, m_cnt, m_ff, m_match); end
        @(negedge clk); rst = 1'b0; inv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (m_busy !== 1'b0 || m_xv !== 1'b0 || m_x !== 7'd0) begin n_fail++; $display("FAIL rstmid_idle got busy=%0b xv=%0b x=%0d want 0 0 0", m_busy, m_xv, m_x); end
        $display("[TB] reset at idx 90: busy=%0b cnt=%0d", m_busy, m_cnt);
    endtask

    initial begin
        rst = 1'b1; tb_start = 1'b0; tb_abort = 1'b0; inv = 1'b0; sel = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst = 1'b0;
        test_match_lat0();
        test_inverted();
        test_lat2();
        test_bit77();
        test_abort();
        test_restart();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
